// File: rtl/hemaia_mem_arb_pkg.sv
// Shared types and width helpers for the HeMAiA super-bank arbiter.
// No logic; imported by the arbiter and its statistics counters.
package hemaia_mem_arb_pkg;

    typedef enum logic {
        WIDE_PRIO   = 1'b0,
        NARROW_PRIO = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hemaia_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible one cycle after the event.
// Backpressure: none; an event is always absorbed, sticking at all-ones.
module hemaia_sat_counter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hemaia_superbank_arbiter.sv
// Wide-vs-narrow arbiter for one super-bank: wide priority with forced narrow windows.
// Latency: grants combinational from state and valids; response select one cycle later.
// Backpressure: a losing request simply sees no grant and must hold its valid.
module hemaia_superbank_arbiter
    import hemaia_mem_arb_pkg::*;
#(
    parameter int NumNarrow   = 8,
    parameter int StarveLimit = 16,
    parameter int NarrowSlots = 4,
    parameter int CntWidth    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wide_valid_i,
    input  logic [NumNarrow-1:0] narrow_valid_i,
    output logic                 sel_wide_o,
    output logic                 wide_gnt_o,
    output logic [NumNarrow-1:0] narrow_gnt_o,
    output logic                 rsp_sel_wide_o,
    output logic                 starve_evt_o,
    input  logic                 stat_clr_i,
    output logic [CntWidth-1:0]  stat_wide_o,
    output logic [CntWidth-1:0]  stat_narrow_o,
    output logic [CntWidth-1:0]  stat_starve_o
);

    localparam int StarveW = cnt_width(StarveLimit);
    localparam int SlotW   = cnt_width(NarrowSlots);

    arb_state_e         state_q, state_d;
    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
    logic [SlotW-1:0]   slot_cnt_q, slot_cnt_d;
    logic               starve_evt_q, starve_evt_d;
    logic               rsp_sel_q;

    logic narrow_any;
    logic narrow_granted;
    logic sel_wide;
    logic force_win;

    assign narrow_any = |narrow_valid_i;

    // Inside a forced window the wide port only gets leftover cycles.
    always_comb begin
        sel_wide = wide_valid_i;
        if (state_q == NARROW_PRIO) begin
            sel_wide = wide_valid_i & ~narrow_any;
        end
    end

    assign sel_wide_o     = sel_wide;
    assign wide_gnt_o     = wide_valid_i & sel_wide;
    assign narrow_gnt_o   = narrow_valid_i & {NumNarrow{~sel_wide}};
    assign narrow_granted = |narrow_gnt_o;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        starve_evt_d = 1'b0;
        force_win    = 1'b0;
        unique case (state_q)
            WIDE_PRIO: begin
                if (narrow_any && sel_wide) begin
                    if (starve_cnt_q == StarveW'(StarveLimit - 1)) begin
                        force_win    = 1'b1;
                        state_d      = NARROW_PRIO;
                        starve_cnt_d = '0;
                        slot_cnt_d   = '0;
                        starve_evt_d = 1'b1;
                    end else begin
                        starve_cnt_d = starve_cnt_q + StarveW'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            NARROW_PRIO: begin
                if (!narrow_any) begin
                    state_d    = WIDE_PRIO;
                    slot_cnt_d = '0;
                end else if (narrow_granted) begin
                    if (slot_cnt_q == SlotW'(NarrowSlots - 1)) begin
                        state_d    = WIDE_PRIO;
                        slot_cnt_d = '0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SlotW'(1);
                    end
                end
            end
            default: begin
                state_d = WIDE_PRIO;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WIDE_PRIO;
            starve_cnt_q <= '0;
            slot_cnt_q   <= '0;
            starve_evt_q <= 1'b0;
            rsp_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            starve_evt_q <= starve_evt_d;
            rsp_sel_q    <= wide_gnt_o;
        end
    end

    assign starve_evt_o   = starve_evt_q;
    assign rsp_sel_wide_o = rsp_sel_q;

    hemaia_sat_counter #(.Width(CntWidth)) u_stat_wide (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wide_gnt_o),
        .clr_i  (stat_clr_i),
        .cnt_o  (stat_wide_o)
    );

    hemaia_sat_counter #(.Width(CntWidth)) u_stat_narrow (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (narrow_granted),
        .clr_i  (stat_clr_i),
        .cnt_o  (stat_narrow_o)
    );

    hemaia_sat_counter #(.Width(CntWidth)) u_stat_starve (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (force_win),
        .clr_i  (stat_clr_i),
        .cnt_o  (stat_starve_o)
    );

endmodule

// File: tb/tb_hemaia_superbank_arbiter.sv
// Directed bench: default-parameter arbiter plus a small one (StarveLimit=1, NarrowSlots=1, 4-bit stats).
module tb_hemaia_superbank_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    logic        wide_valid;
    logic [7:0]  narrow_valid;
    logic        stat_clr;
    logic        sel_wide, wide_gnt, rsp_sel, starve_evt;
    logic [7:0]  narrow_gnt;
    logic [31:0] stat_wide, stat_narrow, stat_starve;

    logic        w2;
    logic [1:0]  n2;
    logic        clr2;
    logic        sel2, wgnt2, rsp2, evt2;
    logic [1:0]  ngnt2;
    logic [3:0]  sw2, sn2, ss2;

    int n_checks = 0;
    int n_fail   = 0;
    int p;
    logic exp_w;

    always #5 clk_i = ~clk_i;

    hemaia_superbank_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wide_valid_i   (wide_valid),
        .narrow_valid_i (narrow_valid),
        .sel_wide_o     (sel_wide),
        .wide_gnt_o     (wide_gnt),
        .narrow_gnt_o   (narrow_gnt),
        .rsp_sel_wide_o (rsp_sel),
        .starve_evt_o   (starve_evt),
        .stat_clr_i     (stat_clr),
        .stat_wide_o    (stat_wide),
        .stat_narrow_o  (stat_narrow),
        .stat_starve_o  (stat_starve)
    );

    hemaia_superbank_arbiter #(
        .NumNarrow   (2),
        .StarveLimit (1),
        .NarrowSlots (1),
        .CntWidth    (4)
    ) dut2 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wide_valid_i   (w2),
        .narrow_valid_i (n2),
        .sel_wide_o     (sel2),
        .wide_gnt_o     (wgnt2),
        .narrow_gnt_o   (ngnt2),
        .rsp_sel_wide_o (rsp2),
        .starve_evt_o   (evt2),
        .stat_clr_i     (clr2),
        .stat_wide_o    (sw2),
        .stat_narrow_o  (sn2),
        .stat_starve_o  (ss2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        wide_valid   = 1'b1;
        narrow_valid = 8'hFF;
        stat_clr     = 1'b0;
        w2           = 1'b0;
        n2           = 2'b00;
        clr2         = 1'b0;

        // During reset: state WIDE_PRIO, registered outputs and stats at 0
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_sel_wide", sel_wide, 1'b1);
        chk("rst_rsp_sel", rsp_sel, 1'b0);
        chk("rst_evt", starve_evt, 1'b0);
        chk("rst_stat_wide", stat_wide, 32'd0);

        // All valids held: period of 16 wide grants, then a 4-cycle narrow window
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 78; c++) begin
            #1;
            p     = c % 20;
            exp_w = (p < 16);
            chk("hold_sel_wide", sel_wide, exp_w);
            chk("hold_wide_gnt", wide_gnt, exp_w);
            chk("hold_narrow_gnt", narrow_gnt, exp_w ? 8'h00 : 8'hFF);
            chk("hold_evt", starve_evt, (p == 16));
            chk("hold_rsp_sel", rsp_sel, (c > 0) && (((c - 1) % 20) < 16));
            if (c == 60) begin
                chk("stat_wide_60", stat_wide, 32'd48);
                chk("stat_narrow_60", stat_narrow, 32'd12);
                chk("stat_starve_60", stat_starve, 32'd3);
            end
            @(negedge clk_i);
        end

        // Cycle 78: third window cycle, narrow drops -> wide granted at once
        narrow_valid = 8'h00;
        #1;
        chk("drop_sel_wide", sel_wide, 1'b1);
        chk("drop_wide_gnt", wide_gnt, 1'b1);
        chk("drop_narrow_gnt", narrow_gnt, 8'h00);
        @(negedge clk_i);
        narrow_valid = 8'hFF;
        #1;
        chk("after_drop_sel_wide", sel_wide, 1'b1);
        chk("after_drop_narrow_gnt", narrow_gnt, 8'h00);

        // Fresh 16-cycle starvation run, then reset inside the window
        repeat (16) @(negedge clk_i);
        #1;
        chk("win2_narrow_gnt", narrow_gnt, 8'hFF);
        chk("win2_evt", starve_evt, 1'b1);
        chk("win2_rsp_sel", rsp_sel, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_rsp_sel", rsp_sel, 1'b0);
        chk("midrst_evt", starve_evt, 1'b0);
        chk("midrst_stat_wide", stat_wide, 32'd0);
        chk("midrst_stat_starve", stat_starve, 32'd0);
        chk("midrst_sel_wide", sel_wide, 1'b1);
        chk("midrst_narrow_gnt", narrow_gnt, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (16) @(negedge clk_i);
        #1;
        chk("restart_evt", starve_evt, 1'b1);
        chk("restart_narrow_gnt", narrow_gnt, 8'hFF);
        chk("restart_stat_starve", stat_starve, 32'd1);
        chk("restart_stat_wide", stat_wide, 32'd16);

        // Narrow-only traffic; clear coincides with a narrow grant
        @(negedge clk_i);
        wide_valid   = 1'b0;
        narrow_valid = 8'h05;
        stat_clr     = 1'b1;
        #1;
        chk("nonly_clr_gnt", narrow_gnt, 8'h05);
        @(negedge clk_i);
        stat_clr = 1'b0;
        #1;
        chk("clr_wins_narrow", stat_narrow, 32'd0);
        chk("clr_wins_wide", stat_wide, 32'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("nonly_gnt", narrow_gnt, 8'h05);
            chk("nonly_sel_wide", sel_wide, 1'b0);
            chk("nonly_wide_gnt", wide_gnt, 1'b0);
            @(negedge clk_i);
        end
        #1;
        chk("nonly_stat_narrow", stat_narrow, 32'd6);

        narrow_valid = 8'h00;
        #1;
        chk("idle_sel_wide", sel_wide, 1'b0);
        chk("idle_wide_gnt", wide_gnt, 1'b0);
        chk("idle_narrow_gnt", narrow_gnt, 8'h00);

        // Small instance: 4-bit stat saturates at 15 and clear wins over an event
        @(negedge clk_i);
        w2 = 1'b1;
        repeat (20) @(negedge clk_i);
        #1;
        chk("sat_stat_wide", sw2, 4'hF);
        clr2 = 1'b1;
        @(negedge clk_i);
        clr2 = 1'b0;
        n2   = 2'b11;
        #1;
        chk("sat_clr_wins", sw2, 4'h0);

        // StarveLimit=1, NarrowSlots=1: strict alternation wide/narrow
        chk("sl1_c0_sel", sel2, 1'b1);
        chk("sl1_c0_ngnt", ngnt2, 2'b00);
        @(negedge clk_i);
        #1;
        chk("sl1_c1_sel", sel2, 1'b0);
        chk("sl1_c1_ngnt", ngnt2, 2'b11);
        chk("sl1_c1_evt", evt2, 1'b1);
        @(negedge clk_i);
        #1;
        chk("sl1_c2_sel", sel2, 1'b1);
        chk("sl1_c2_evt", evt2, 1'b0);
        @(negedge clk_i);
        #1;
        chk("sl1_c3_ngnt", ngnt2, 2'b11);
        chk("sl1_c3_evt", evt2, 1'b1);
        @(negedge clk_i);
        #1;
        chk("sl1_stat_starve", ss2, 4'd2);
        chk("sl1_stat_narrow", sn2, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
